// File: rtl/pool2d_stream_param.sv
// Streaming KxK / stride-K pooling over CH lockstep lanes, runtime max/average, signed data.
// Optional fused ReLU on the pooled result when POOL_RELU_EN is defined.
module pool2d_stream_param #(
  parameter int DATA_W = 16,
  parameter int CH     = 32,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int K      = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 mode_i,
  input  logic                 in_valid_i,
  input  logic [CH*DATA_W-1:0] in_data_i,
  output logic                 out_valid_o,
  output logic [CH*DATA_W-1:0] out_data_o,
  output logic                 busy_o,
  output logic                 frame_done_o
);

  // state | meaning
  // IDLE  | waiting for start, input ignored
  // RUN   | accepting beats of the current frame
  // DONE  | one cycle after the last beat, then IDLE
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int LOG2K = (K == 4) ? 2 : 1;
  localparam int SH    = 2 * LOG2K;
  localparam int SUM_W = DATA_W + SH;
  localparam int LBD   = IMG_W / K;
  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int LBW   = (LBD > 1) ? $clog2(LBD) : 1;

  state_t                     state_q;
  logic [CW-1:0]              col_q;
  logic [RW-1:0]              row_q;
  logic                       mode_q;
  logic                       busy_q;
  logic                       out_valid_q;
  logic                       frame_done_q;
  logic [CH*DATA_W-1:0]       out_data_q;
  logic signed [SUM_W-1:0]    hacc_q [CH];
  logic signed [SUM_W-1:0]    lb_q   [CH][LBD];

  logic signed [SUM_W-1:0]    hacc_d [CH];
  logic signed [SUM_W-1:0]    vmrg_d [CH];
  logic [CH*DATA_W-1:0]       res_d;

  logic [LOG2K-1:0] hpos;
  logic [LOG2K-1:0] vpos;
  logic [LBW-1:0]   lb_idx;
  logic             h_last;
  logic             v_first;
  logic             v_last;
  logic             col_last;
  logic             row_last;

  assign hpos     = col_q[LOG2K-1:0];
  assign vpos     = row_q[LOG2K-1:0];
  assign lb_idx   = LBW'(col_q >> LOG2K);
  assign h_last   = &hpos;
  assign v_first  = (vpos == '0);
  assign v_last   = &vpos;
  assign col_last = (col_q == CW'(IMG_W - 1));
  assign row_last = (row_q == RW'(IMG_H - 1));

  function automatic logic signed [SUM_W-1:0] merge(input logic avg,
                                                    input logic signed [SUM_W-1:0] a,
                                                    input logic signed [SUM_W-1:0] b);
    if (avg) return a + b;
    return (a > b) ? a : b;
  endfunction

  // Max values are kept sign-extended at SUM_W so both modes share the same datapath.
  always_comb begin
    res_d = '0;
    for (int i = 0; i < CH; i++) begin
      logic signed [SUM_W-1:0]  xe;
      logic signed [SUM_W-1:0]  v;
      logic signed [DATA_W-1:0] r;
      xe = {{SH{in_data_i[i*DATA_W+DATA_W-1]}}, in_data_i[i*DATA_W +: DATA_W]};
      hacc_d[i] = (hpos == '0) ? xe : merge(mode_q, hacc_q[i], xe);
      vmrg_d[i] = v_first ? hacc_d[i] : merge(mode_q, lb_q[i][lb_idx], hacc_d[i]);
      v = vmrg_d[i];
      r = mode_q ? DATA_W'(v >>> SH) : DATA_W'(v);
`ifdef POOL_RELU_EN
      if (r[DATA_W-1]) r = '0;
`endif
      res_d[i*DATA_W +: DATA_W] = r;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      mode_q       <= 1'b0;
      busy_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      out_data_q   <= '0;
      for (int i = 0; i < CH; i++) begin
        hacc_q[i] <= '0;
        for (int j = 0; j < LBD; j++) lb_q[i][j] <= '0;
      end
    end else begin
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      if (start_i) begin
        // Restart from any state; stale window data is overwritten by the first row of the new frame.
        state_q <= RUN;
        busy_q  <= 1'b1;
        col_q   <= '0;
        row_q   <= '0;
        mode_q  <= mode_i;
      end else begin
        case (state_q)
          RUN: begin
            if (in_valid_i) begin
              if (col_last) begin
                col_q <= '0;
                row_q <= row_last ? '0 : row_q + RW'(1);
              end else begin
                col_q <= col_q + CW'(1);
              end
              for (int i = 0; i < CH; i++) hacc_q[i] <= hacc_d[i];
              if (h_last && !v_last) begin
                for (int i = 0; i < CH; i++) lb_q[i][lb_idx] <= vmrg_d[i];
              end
              if (h_last && v_last) begin
                out_valid_q  <= 1'b1;
                out_data_q   <= res_d;
                frame_done_q <= col_last && row_last;
              end
              if (col_last && row_last) state_q <= DONE;
            end
          end
          DONE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_data_o   = out_data_q;
  assign busy_o       = busy_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_pool2d_stream_param.sv
// Bench for pool2d_stream_param: a small 2-lane 4x4 instance and a default-parameter instance,
// each checked against a queue of expected windows built from the driven frame.
module tb_pool2d_stream_param;
  localparam int DW  = 16;
  localparam int SCH = 2;
  localparam int SW  = 4;
  localparam int DCH = 32;
  localparam int DIW = 28;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic               start_s, mode_s, iv_s, ov_s, busy_s, fd_s;
  logic [SCH*DW-1:0]  id_s, od_s;
  logic               start_d, mode_d, iv_d, ov_d, busy_d, fd_d;
  logic [DCH*DW-1:0]  id_d, od_d;

  pool2d_stream_param #(.DATA_W(DW), .CH(SCH), .IMG_W(SW), .IMG_H(SW), .K(2)) dut_s (
    .clk_i(clk), .rst_i(rst), .start_i(start_s), .mode_i(mode_s), .in_valid_i(iv_s),
    .in_data_i(id_s), .out_valid_o(ov_s), .out_data_o(od_s), .busy_o(busy_s),
    .frame_done_o(fd_s));

  pool2d_stream_param dut_d (
    .clk_i(clk), .rst_i(rst), .start_i(start_d), .mode_i(mode_d), .in_valid_i(iv_d),
    .in_data_i(id_d), .out_valid_o(ov_d), .out_data_o(od_d), .busy_o(busy_d),
    .frame_done_o(fd_d));

  typedef struct packed { logic done; logic [SCH*DW-1:0] d; } exp_s_t;
  typedef struct packed { logic done; logic [DCH*DW-1:0] d; } exp_d_t;

  exp_s_t q_s[$];
  exp_d_t q_d[$];
  exp_s_t e_s;
  exp_d_t e_d;

  int tests = 0;
  int fails = 0;
  int outs_s = 0, dones_s = 0, outs_d = 0, dones_d = 0;

  int          frm_s [SCH][SW][SW];
  bit          avg_s;
  logic [DCH*DW-1:0] frm_d [DIW][DIW];

  task automatic chk(input string tag, input logic [DCH*DW-1:0] obs, input logic [DCH*DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference window from the stored frame, independent of the DUT's streaming structure.
  function automatic logic [DW-1:0] model_s(int l, int r, int c);
    int acc, mx, v;
    acc = 0;
    mx  = frm_s[l][r-1][c-1];
    for (int dr = 0; dr < 2; dr++)
      for (int dc = 0; dc < 2; dc++) begin
        v = frm_s[l][r-1+dr][c-1+dc];
        acc += v;
        if (v > mx) mx = v;
      end
    v = avg_s ? (acc >>> 2) : mx;
`ifdef POOL_RELU_EN
    if (v < 0) v = 0;
`endif
    return DW'(v);
  endfunction

  function automatic logic [DCH*DW-1:0] model_d(int r, int c);
    logic [DCH*DW-1:0] res;
    logic signed [DW-1:0] mx, v;
    res = '0;
    for (int l = 0; l < DCH; l++) begin
      mx = frm_d[r-1][c-1][l*DW +: DW];
      for (int dr = 0; dr < 2; dr++)
        for (int dc = 0; dc < 2; dc++) begin
          v = frm_d[r-1+dr][c-1+dc][l*DW +: DW];
          if (v > mx) mx = v;
        end
`ifdef POOL_RELU_EN
      if (mx < 0) mx = '0;
`endif
      res[l*DW +: DW] = mx;
    end
    return res;
  endfunction

  always @(negedge clk) begin
    if (ov_s) begin
      outs_s++;
      if (fd_s) dones_s++;
      tests++;
      assert (q_s.size() != 0) else begin
        fails++;
        $error("FAIL s_unexpected_out: out_valid with no pending window, data %0h", od_s);
      end
      if (q_s.size() != 0) begin
        e_s = q_s.pop_front();
        chk("s_data", od_s, e_s.d);
        chk("s_frame_done", fd_s, e_s.done);
      end
    end else if (fd_s) begin
      chk("s_done_without_valid", fd_s, 0);
    end
  end

  always @(negedge clk) begin
    if (ov_d) begin
      outs_d++;
      if (fd_d) dones_d++;
      tests++;
      assert (q_d.size() != 0) else begin
        fails++;
        $error("FAIL d_unexpected_out: out_valid with no pending window");
      end
      if (q_d.size() != 0) begin
        e_d = q_d.pop_front();
        chk("d_data", od_d, e_d.d);
        chk("d_frame_done", fd_d, e_d.done);
      end
    end else if (fd_d) begin
      chk("d_done_without_valid", fd_d, 0);
    end
  end

  task automatic fill_s(input int pat);
    for (int i = 0; i < SW*SW; i++) begin
      case (pat)
        0: begin frm_s[0][i/SW][i%SW] = i; frm_s[1][i/SW][i%SW] = (i*37) % 50 - 25; end
        1: begin frm_s[0][i/SW][i%SW] = i; frm_s[1][i/SW][i%SW] = -3; end
        default: begin frm_s[0][i/SW][i%SW] = 1000 - 77*i; frm_s[1][i/SW][i%SW] = i*i - 50; end
      endcase
    end
  endtask

  task automatic start_s_t(input bit avg);
    start_s = 1'b1;
    mode_s  = avg;
    avg_s   = avg;
    tick();
    start_s = 1'b0;
    mode_s  = 1'b0;
  endtask

  task automatic send_s(input int r, input int c);
    exp_s_t e;
    iv_s = 1'b1;
    for (int l = 0; l < SCH; l++) id_s[l*DW +: DW] = DW'(frm_s[l][r][c]);
    if (r % 2 == 1 && c % 2 == 1) begin
      e.done = (r == SW-1) && (c == SW-1);
      for (int l = 0; l < SCH; l++) e.d[l*DW +: DW] = model_s(l, r, c);
      q_s.push_back(e);
    end
    tick();
    iv_s = 1'b0;
  endtask

  task automatic beats_s(input int n, input int gap_every);
    for (int idx = 0; idx < n; idx++) begin
      send_s(idx / SW, idx % SW);
      if (gap_every > 0 && (idx + 1) % gap_every == 0) tick();
    end
  endtask

  task automatic drain_s();
    for (int i = 0; i < 10 && q_s.size() != 0; i++) tick();
    tests++;
    assert (q_s.size() == 0) else begin
      fails++;
      $error("FAIL s_drain: %0d windows still pending, expected 0", q_s.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int o0, d0;
    rst = 1'b1;
    start_s = 0; mode_s = 0; iv_s = 0; id_s = '0; avg_s = 0;
    start_d = 0; mode_d = 0; iv_d = 0; id_d = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("s_rst_out_valid", ov_s, 0);
    chk("s_rst_out_data", od_s, 0);
    chk("s_rst_busy", busy_s, 0);
    chk("s_rst_frame_done", fd_s, 0);
    chk("d_rst_out_valid", ov_d, 0);
    chk("d_rst_out_data", od_d, 0);
    chk("d_rst_busy", busy_d, 0);
    rst = 1'b0;
    tick();

    // max frame, ramp on lane 0 and mixed-sign lane 1
    o0 = outs_s; d0 = dones_s;
    fill_s(0);
    start_s_t(0);
    chk("s_busy_after_start", busy_s, 1);
    beats_s(16, 0);
    chk("s_busy_in_done", busy_s, 1);
    tick();
    chk("s_busy_idle", busy_s, 0);
    drain_s();
    chk("s_max_count", outs_s - o0, 4);
    chk("s_max_dones", dones_s - d0, 1);

    // average frame, then a new start while still in DONE
    o0 = outs_s; d0 = dones_s;
    start_s_t(1);
    beats_s(16, 0);
    fill_s(1);
    start_s_t(1);
    chk("s_busy_restart_from_done", busy_s, 1);
    beats_s(16, 0);
    tick();
    drain_s();
    chk("s_avg_count", outs_s - o0, 8);
    chk("s_avg_dones", dones_s - d0, 2);

    // beats in IDLE are ignored; next frame with gaps must be unaffected
    for (int i = 0; i < 6; i++) begin
      iv_s = 1'b1;
      id_s = {16'h7fff, 16'h7fff};
      tick();
    end
    iv_s = 1'b0;
    chk("s_idle_busy", busy_s, 0);
    o0 = outs_s;
    fill_s(2);
    start_s_t(0);
    beats_s(16, 3);
    tick();
    drain_s();
    chk("s_gap_count", outs_s - o0, 4);

    // restart after 10 beats: windows already completed are emitted, then exactly 4 from the new frame
    fill_s(0);
    start_s_t(1);
    beats_s(10, 0);
    drain_s();
    o0 = outs_s; d0 = dones_s;
    fill_s(2);
    start_s_t(0);
    beats_s(16, 0);
    tick();
    drain_s();
    chk("s_restart_count", outs_s - o0, 4);
    chk("s_restart_dones", dones_s - d0, 1);

    // async reset mid-frame at beat 9
    fill_s(0);
    start_s_t(0);
    beats_s(9, 0);
    drain_s();
    iv_s = 1'b1;
    id_s = {DW'(frm_s[1][2][1]), DW'(frm_s[0][2][1])};
    #2;
    rst = 1'b1;
    #1;
    chk("s_async_out_valid", ov_s, 0);
    chk("s_async_out_data", od_s, 0);
    chk("s_async_busy", busy_s, 0);
    chk("s_async_frame_done", fd_s, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    o0 = outs_s;
    for (int i = 0; i < 8; i++) tick();
    iv_s = 1'b0;
    chk("s_post_rst_no_out", outs_s - o0, 0);
    chk("s_post_rst_busy", busy_s, 0);
    fill_s(2);
    start_s_t(0);
    beats_s(16, 0);
    tick();
    drain_s();
    chk("s_post_rst_count", outs_s - o0, 4);

    // default-parameter instance, random data, gap after every 3rd beat
    for (int r = 0; r < DIW; r++)
      for (int c = 0; c < DIW; c++)
        for (int l = 0; l < DCH; l++) frm_d[r][c][l*DW +: DW] = DW'($urandom);
    o0 = outs_d; d0 = dones_d;
    start_d = 1'b1;
    mode_d  = 1'b0;
    tick();
    start_d = 1'b0;
    for (int idx = 0; idx < DIW*DIW; idx++) begin
      int r, c;
      r = idx / DIW;
      c = idx % DIW;
      iv_d = 1'b1;
      id_d = frm_d[r][c];
      if (r % 2 == 1 && c % 2 == 1) begin
        exp_d_t e;
        e.done = (r == DIW-1) && (c == DIW-1);
        e.d    = model_d(r, c);
        q_d.push_back(e);
      end
      tick();
      iv_d = 1'b0;
      if ((idx + 1) % 3 == 0) tick();
    end
    chk("d_busy_in_done", busy_d, 1);
    tick();
    chk("d_busy_idle", busy_d, 0);
    for (int i = 0; i < 10 && q_d.size() != 0; i++) tick();
    chk("d_drain", q_d.size(), 0);
    chk("d_count", outs_d - o0, 196);
    chk("d_dones", dones_d - d0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pool2d_stream_param.md
Name: pool2d_stream_param

Overview:
- Parametrised streaming 2-D pooling engine; successor to the fixed 28x28, 2x2, 16-bit per-column pooling block.
- Consumes a raster-order feature map from CH systolic-array columns in lockstep and emits one pooled value per lane per KxK window, stride K.
- Adds runtime max/average mode, signed data, generic image size and window, back-pressure-free gapped input, and a frame-done flag.

Parameters:
- DATA_W, 16, lane data width; signed two's complement.
- CH, 32, number of parallel lanes; all lanes share one control path.
- IMG_W, 28, input columns per frame; IMG_W % K == 0 required.
- IMG_H, 28, input rows per frame; IMG_H % K == 0 required.
- K, 2, window size and stride; legal values 2 or 4.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; arms a new frame and latches mode.
- mode  in  1  0 = max, 1 = average; sampled only on start.
- in_valid  in  1  input beat qualifier; gaps allowed.
- in_data  in  CH*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W].
- out_valid  out  1  one-cycle pulse per pooled window.
- out_data  out  CH*DATA_W  pooled result per lane; same packing as in_data.
- busy  out  1  high while a frame is in progress.
- frame_done  out  1  one-cycle pulse with the final out_valid of a frame.

Behaviour:
- Reset values: out_valid=0, out_data=0, busy=0, frame_done=0, state=IDLE, all counters and buffers cleared.
- FSM states:
  - IDLE: start -> RUN. busy=1 from the cycle after start. Clears col/row counters and latches mode.
  - RUN: in_valid beats are accepted. Last beat of the frame -> DONE.
  - DONE: one cycle, then IDLE. start while in DONE is honoured the same cycle as in IDLE.
- start in RUN restarts the frame: counters cleared, mode re-latched, partial window data discarded, no output for the aborted frame.
- in_valid in IDLE or DONE is ignored.
- Counters:
  - col counts 0..IMG_W-1, then wraps; row increments on the wrap.
  - The last beat is col=IMG_W-1, row=IMG_H-1.
- Horizontal stage: per lane, accumulate K consecutive beats (running max, or sign-extended sum).
- Vertical stage: on completion of each horizontal group, merge with line-buffer entry col/K (depth IMG_W/K per lane).
  - Window row 0 (row%K==0): overwrite the entry.
  - Other window rows: merge with the entry.
  - Window row K-1: produce the result and do not write back.
- Sum width: DATA_W+2*log2(K).
- Average result: arithmetic right shift by 2*log2(K), which floors toward -inf. Result always fits DATA_W; no saturation needed.
- Max compare is signed.
- Latency: out_valid is registered; asserted the cycle after the in_valid beat at col%K==K-1, row%K==K-1.
- Outputs per frame: exactly (IMG_W/K)*(IMG_H/K), i.e. 196 for default parameters.
- out_data holds its value until the next out_valid.
- frame_done is coincident with the last out_valid.
- Async reset mid-frame: immediate return to reset values. No output until a new start.

Optional Feature:
- Macro POOL_RELU_EN.
- When defined: each lane's pooled result is clamped to 0 when negative before out_data registration (fused ReLU); no latency change.
- When undefined: negative results pass unchanged.

Test Plan:
- CH=2, IMG_W=IMG_H=4, K=2, max, lane0 = 0..15 raster with no gaps -> out_valid 4 times, lane0 = 5,7,13,15; frame_done with the 4th output.
- Same frame, mode=1 (avg) -> lane0 = 2,4,10,12 (floors of 2.5,4.5,10.5,12.5).
- Lane1 all -3, avg mode, DATA_W=16 -> lane1 = 0xFFFD each window. Same stimulus with POOL_RELU_EN defined -> 0x0000.
- Default parameters, 784 beats with a 1-cycle gap after every 3rd beat -> exactly 196 out_valid pulses; values match a per-lane software 2x2 max model; busy low 2 cycles after the last beat.
- start asserted after 10 beats, then a full clean 4x4 frame -> only 4 outputs, all from the second frame.
- rst asserted at beat 9 of a 4x4 frame -> outputs and busy go 0 asynchronously; in_valid ignored until the next start; a subsequent clean frame produces correct results.
